// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: fun3 encodings, FSM states, sizes.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
   localparam int unsigned CNT_W                  = 8;
   localparam int unsigned XLEN                   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication/byte mask, load extract and extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      st_fun3,
   input  logic [1:0]      st_off,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] wdata_c,
   output logic [3:0]      wmask_c,
   input  logic [2:0]      ld_fun3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] load_ext_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      wdata_c = store_data;
      wmask_c = 4'b1111;
      case (st_fun3)
         F3_B: begin
            wdata_c = {4{store_data[7:0]}};
            wmask_c = 4'b0001 << st_off;
         end
         F3_H: begin
            wdata_c = {2{store_data[15:0]}};
            wmask_c = st_off[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte    = rdata[7:0];
      ld_half    = ld_off[1] ? rdata[31:16] : rdata[15:0];
      load_ext_c = rdata;
      case (ld_off)
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         2'd3:    ld_byte = rdata[31:24];
         default: ld_byte = rdata[7:0];
      endcase
      case (ld_fun3)
         F3_B:    load_ext_c = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_ext_c = {24'd0, ld_byte};
         F3_H:    load_ext_c = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_ext_c = {16'd0, ld_half};
         default: load_ext_c = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory stage: legality check, valid/ready bus FSM with timeout,
// and registered load result for writeback.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  fun3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        access_fault,
   output logic        bus_error,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   lsu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       fun3_q;
   logic [1:0]       off_q;
   logic             legal_c;
   logic             timeout_c;
   logic [31:0]      wdata_c;
   logic [3:0]       wmask_c;
   logic [31:0]      load_ext_c;

   lsu_align u_align (
      .st_fun3    (fun3),
      .st_off     (addr[1:0]),
      .store_data (store_data),
      .wdata_c    (wdata_c),
      .wmask_c    (wmask_c),
      .ld_fun3    (fun3_q),
      .ld_off     (off_q),
      .rdata      (mem_rdata),
      .load_ext_c (load_ext_c)
   );

   // Exactly one strobe, a size legal for its direction, naturally aligned.
   always_comb begin
      legal_c = 1'b0;
      if (load ^ store) begin
         case (fun3)
            F3_B:    legal_c = 1'b1;
            F3_H:    legal_c = ~addr[0];
            F3_W:    legal_c = (addr[1:0] == 2'b00);
            F3_BU:   legal_c = load;
            F3_HU:   legal_c = load & ~addr[0];
            default: legal_c = 1'b0;
         endcase
      end
   end

   assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign stall     = ((state == IDLE) && legal_c) || (state == REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         fun3_q       <= 3'd0;
         off_q        <= 2'd0;
         load_data    <= '0;
         access_fault <= 1'b0;
         bus_error    <= 1'b0;
         mem_valid    <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wmask    <= 4'd0;
      end else begin
         access_fault <= 1'b0;
         bus_error    <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (legal_c) begin
                  mem_valid <= 1'b1;
                  mem_we    <= store;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_wdata <= wdata_c;
                  mem_wmask <= store ? wmask_c : 4'd0;
                  fun3_q    <= fun3;
                  off_q     <= addr[1:0];
                  state     <= REQ;
               end else if (load | store) begin
                  access_fault <= 1'b1;
                  load_data    <= '0;
               end
            end
            // Ready wins over a timeout landing in the same cycle.
            REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!mem_we) load_data <= load_ext_c;
                  state <= DONE;
               end else if (timeout_c) begin
                  mem_valid <= 1'b0;
                  load_data <= '0;
                  bus_error <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, store;
   logic [2:0]  fun3;
   logic [31:0] addr, store_data, mem_rdata;
   logic        ready_a;

   logic        stall, access_fault, bus_error, mem_valid, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;

   logic        stall_b, access_fault_b, bus_error_b, mem_valid_b, mem_we_b;
   logic [31:0] load_data_b, mem_addr_b, mem_wdata_b;
   logic [3:0]  mem_wmask_b;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_ld;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3), .addr(addr),
      .store_data(store_data), .stall(stall), .load_data(load_data),
      .access_fault(access_fault), .bus_error(bus_error), .mem_valid(mem_valid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ready(ready_a), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_t4 (
      .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3), .addr(addr),
      .store_data(store_data), .stall(stall_b), .load_data(load_data_b),
      .access_fault(access_fault_b), .bus_error(bus_error_b), .mem_valid(mem_valid_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_wmask(mem_wmask_b), .mem_ready(ready_a), .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_legal(input logic ld, input logic st, input logic [2:0] f3,
                                    input logic [31:0] a);
      int sz;
      if (ld == st) return 1'b0;
      if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
      if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      sz = 1 << f3[1:0];
      return (int'(a[1:0]) % sz) == 0;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] b, h;
      b = d & 32'hFF;
      h = d & 32'hFFFF;
      if (f3 == 3'd0) return b * 32'h01010101;
      if (f3 == 3'd1) return h * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] m_wmask(input logic [2:0] f3, input logic [31:0] a);
      int off;
      off = int'(a[1:0]);
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] sh, v;
      sh = rd >> (8 * int'(a[1:0]));
      case (f3)
         3'd0: begin v = sh & 32'hFF;   return (v >= 32'd128)   ? v - 32'd256   : v; end
         3'd1: begin v = sh & 32'hFFFF; return (v >= 32'd32768) ? v - 32'd65536 : v; end
         3'd4: return sh & 32'hFF;
         3'd5: return sh & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   // Issue one instruction from IDLE, hold ready low for 'waits' REQ cycles,
   // and check every cycle until the unit is back in IDLE.
   task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int waits,
                         input logic [31:0] rd);
      logic        ok;
      logic [3:0]  em;
      ok = m_legal(ld, st, f3, a);
      em = st ? m_wmask(f3, a) : 4'd0;
      load = ld; store = st; fun3 = f3; addr = a; store_data = d;
      ready_a = 1'b0; mem_rdata = $urandom;
      #1 check("stall_idle", stall, ok);
      @(posedge clk); @(negedge clk);
      load = 1'b0; store = 1'b0; addr = $urandom; store_data = $urandom;
      if (!ok) begin
         if (ld | st) m_ld = 32'd0;
         #1;
         check("fault_pulse", access_fault, ld | st);
         check("fault_novalid", mem_valid, 1'b0);
         check("fault_stall", stall, 1'b0);
         check("fault_ldata", load_data, m_ld);
         @(posedge clk); @(negedge clk);
         #1 check("fault_clear", access_fault, 1'b0);
         return;
      end
      for (int i = 0; i <= waits; i++) begin
         ready_a = (i == waits);
         mem_rdata = (i == waits) ? rd : $urandom;
         #1;
         check("req_valid", mem_valid, 1'b1);
         check("req_stall", stall, 1'b1);
         check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
         check("req_we", mem_we, st);
         check("req_wmask", mem_wmask, em);
         if (st) check("req_wdata", mem_wdata, m_wdata(f3, d));
         @(posedge clk); @(negedge clk);
      end
      ready_a = 1'b0; mem_rdata = $urandom;
      if (ld) m_ld = m_load(f3, a, rd);
      #1;
      check("done_stall", stall, 1'b0);
      check("done_valid", mem_valid, 1'b0);
      check("done_buserr", bus_error, 1'b0);
      check("done_ldata", load_data, m_ld);
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; store = 1'b0; fun3 = 3'd0; addr = '0; store_data = '0;
      ready_a = 1'b0; mem_rdata = '0; m_ld = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", mem_valid, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_wmask", mem_wmask, 4'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_ldata", load_data, 32'd0);
      check("rst_fault", access_fault, 1'b0);
      check("rst_buserr", bus_error, 1'b0);
      check("rst_stall", stall, 1'b0);
      rst = 1'b0;

      access(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
      check("lw_const", load_data, 32'hDEADBEEF);
      access(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80123456);
      check("lb_const", load_data, 32'hFFFFFF80);
      access(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80123456);
      check("lbu_const", load_data, 32'h00000080);
      access(1, 0, 3'd5, 32'h102, 32'h0, 0, 32'h80123456);
      check("lhu_const", load_data, 32'h00008012);
      access(0, 1, 3'd0, 32'h202, 32'h12345678, 0, 32'h0);
      access(0, 1, 3'd1, 32'h202, 32'h12345678, 2, 32'h0);
      access(0, 1, 3'd1, 32'h201, 32'h12345678, 0, 32'h0);
      access(1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0);
      access(1, 0, 3'd3, 32'h100, 32'h0, 0, 32'h0);
      access(1, 1, 3'd2, 32'h100, 32'h0, 0, 32'h0);
      access(0, 1, 3'd2, 32'h104, 32'hA5A5_0F0F, 5, 32'h0);

      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 9);
         access(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom_range(0, 5), $urandom);
      end

      // Short-timeout instance: ready never comes.
      access(1, 0, 3'd2, 32'h2F0, 32'h0, 0, 32'hCAFEF00D);
      load = 1'b1; fun3 = 3'd2; addr = 32'h300; ready_a = 1'b0;
      @(posedge clk); @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t4_valid", mem_valid_b, 1'b1);
         check("t4_noerr", bus_error_b, 1'b0);
         @(posedge clk); @(negedge clk);
      end
      #1;
      check("t4_drop", mem_valid_b, 1'b0);
      check("t4_buserr", bus_error_b, 1'b1);
      check("t4_ldata", load_data_b, 32'd0);
      check("t4_stall", stall_b, 1'b0);
      @(posedge clk); @(negedge clk);
      #1 check("t4_errclr", bus_error_b, 1'b0);

      // Reset while the default instance is still waiting.
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; m_ld = 32'd0;
      #1;
      check("rst_mid_valid", mem_valid, 1'b0);
      check("rst_mid_stall", stall, 1'b0);
      check("rst_mid_ldata", load_data, m_ld);

      // Default timeout: 255 REQ cycles then abort.
      access(1, 0, 3'd2, 32'h3F0, 32'h0, 0, 32'h1234_5678);
      load = 1'b1; fun3 = 3'd2; addr = 32'h400; ready_a = 1'b0;
      @(posedge clk); @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 255; k++) begin
         #1 check("t255_valid", mem_valid, 1'b1);
         @(posedge clk); @(negedge clk);
      end
      m_ld = 32'd0;
      #1;
      check("t255_drop", mem_valid, 1'b0);
      check("t255_buserr", bus_error, 1'b1);
      check("t255_ldata", load_data, m_ld);
      check("t255_stall", stall, 1'b0);
      @(posedge clk); @(negedge clk);

      // Reset in the second REQ cycle of a store.
      store = 1'b1; fun3 = 3'd2; addr = 32'h500; store_data = 32'h0BAD_F00D; ready_a = 1'b0;
      @(posedge clk); @(negedge clk);
      store = 1'b0;
      @(posedge clk); @(negedge clk);
      #1 check("sw_req2_valid", mem_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      check("sw_rst_valid", mem_valid, 1'b0);
      check("sw_rst_stall", stall, 1'b0);
      check("sw_rst_fault", access_fault, 1'b0);
      check("sw_rst_buserr", bus_error, 1'b0);
      @(posedge clk); @(negedge clk);
      #1;
      check("sw_rst_fault2", access_fault, 1'b0);
      check("sw_rst_buserr2", bus_error, 1'b0);
      access(1, 0, 3'd2, 32'h600, 32'h0, 1, 32'h600D_CAFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
